bcd_counter_display: RTL and testbench
======================================

// Module: bcd_counter_display
// PURPOSE
//  Parametrised NDIG-digit decimal (BCD) up/down counter with built-in prescaler
//  and per-digit 7-segment decode. Replaces the separate divider, mod-10 counter and
//  decoder chain on the DE2 top level. Drives HEX displays directly from CLOCK_50.
//  Adds over a single mod-10 stage:
//  - multi-digit ripple carry/borrow
//  - count direction
//  - synchronous load
//  - count enable
//  - wrap flag
//  - leading-zero blanking
// PARAMETERS
//  NDIG  4           number of BCD digits; legal 1..8
//  DIV   50_000_000  clk cycles per count step; legal >= 1 (1 = step every enabled cycle)
// PORTS
//  clk       in   1        system clock (CLOCK_50); all state on rising edge
//  rst       in   1        synchronous reset, active-high
//  en        in   1        count enable; 0 freezes prescaler and count
//  up        in   1        direction: 1 = increment, 0 = decrement
//  load      in   1        synchronous load of load_val
//  load_val  in   4*NDIG   BCD value to load; digit i at [4*i+:4], digit 0 = least significant
//  blank_lz  in   1        1 = blank leading-zero digits
//  bcd       out  4*NDIG   current count, BCD, same digit packing as load_val
//  seg       out  7*NDIG   active-low segments, digit i at [7*i+:7]
//                          a at bit 7*i+6 ... g at bit 7*i+0, so a slice maps onto a HEXn[0:6] port
//  tick      out  1        1-cycle pulse, high in the cycle the count takes a stepped value
//  wrap      out  1        1-cycle pulse, high with tick when the step wrapped (99..9->0 or 0->99..9)
// BEHAVIOUR
//  Reset
//  - rst=1 at an edge: prescaler=0, bcd=0, tick=0, wrap=0.
//  - rst overrides load and en; reset mid-count discards the partial prescale.
//  Priority each edge: rst > load > step.
//  Prescaler
//  - pcnt counts 0..DIV-1 while en=1 and holds while en=0.
//  - step_int = en & (pcnt==DIV-1); pcnt then returns to 0.
//  - DIV=1: step_int = en every cycle.
//  Load
//  - load=1: bcd <= load_val and pcnt <= 0, regardless of en.
//  - A step coinciding with load is discarded; tick=0 and wrap=0 on the next cycle.
//  - Any load_val digit >9 is loaded as 0; valid digits are unaffected.
//  Step (load=0, step_int=1)
//  - up=1: digit 0 increments. A digit at 9 goes to 0 and carries to the next digit.
//    All 9s -> all 0s and wrap.
//  - up=0: digit 0 decrements. A digit at 0 goes to 9 and borrows. All 0s -> all 9s and wrap.
//  - Carry/borrow ripples combinationally across all NDIG digits in one cycle.
//    There is no multi-cycle ripple.
//  - up is sampled on the step edge only; changing it between steps is legal.
//  Flags
//  - tick and wrap are registered on the same edge that updates bcd.
//  - Latency: the step edge updates bcd, tick and wrap together.
//  - tick/wrap are 0 in every cycle that does not follow a step.
//  Segments
//  - seg is combinational from bcd; there is no extra latency.
//  - Active-low codes (abcdefg):
//      0=0000001  1=1001111  2=0010010  3=0000110  4=1001100
//      5=0100100  6=0100000  7=0001111  8=0000000  9=0000100
//    Any other value displays 1111111.
//  - blank_lz=1: digit i>0 shows 1111111 when it and every more-significant digit are 0.
//    Digit 0 is never blanked; value 0 shows a single "0".
//  - blank_lz affects seg only, never bcd.
// TESTING (NDIG=2, DIV=4 unless stated)
//  1 Reset: rst=1 for 2 cycles with load=1, en=1
//    -> bcd=8'h00, seg=14'b0000001_0000001, tick=0, wrap=0.
//  2 Up count: en=1, up=1 from 0 -> bcd steps every 4 cycles; tick high 1 cycle per step.
//    After 10 steps bcd=8'h10. 98->99->00 with wrap=1 only at 00.
//  3 Down/borrow: load_val=8'h10, load=1 for 1 cycle, then up=0
//    -> first step gives 8'h09 with wrap=0. From 8'h00 the next step gives 8'h99 with wrap=1.
//  4 Hold/load priority: en=0 for 20 cycles -> bcd and pcnt unchanged, no tick.
//    load in the cycle step_int=1 with load_val=8'h3C -> bcd=8'h30, tick=0.
//  5 Blanking: blank_lz=1, bcd=8'h07 -> seg=14'b1111111_0001111.
//    bcd=8'h00 -> seg=14'b1111111_0000001. blank_lz=0 -> seg=14'b0000001_0000001.
//  6 DIV=1, NDIG=4: en=1 from 9999 with up=1 -> next cycle bcd=16'h0000, tick=1, wrap=1.
//    rst mid-run -> 0 on the following edge.

Source files
------------

// File: rtl/bcd_counter_display.sv
// NDIG-digit BCD up/down counter with a prescaler and per-digit active-low 7-segment decode.
// Carry/borrow ripples through all digits in a single cycle; seg is combinational from bcd.
module bcd_counter_display #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned DIV  = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  input  logic                blank_lz,
  output logic [4*NDIG-1:0]   bcd,
  output logic [7*NDIG-1:0]   seg,
  output logic                tick,
  output logic                wrap
);

  localparam int unsigned BW = 4 * NDIG;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [PW-1:0] pcnt;
  logic          step_int;
  logic [BW-1:0] stepped;
  logic [BW-1:0] loaded;
  logic          wrapped;

  assign step_int = en && (pcnt == PMAX);

  // Next count value one step away, with the carry/borrow out of the top digit as the wrap
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    stepped = '0;
    carry   = 1'b1;
    dig     = 4'd0;
    for (int i = 0; i < int'(NDIG); i++) begin
      dig = bcd[4*i +: 4];
      if (!carry) begin
        stepped[4*i +: 4] = dig;
      end else if (up) begin
        if (dig == 4'd9) begin
          stepped[4*i +: 4] = 4'd0;
        end else begin
          stepped[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end else begin
        if (dig == 4'd0) begin
          stepped[4*i +: 4] = 4'd9;
        end else begin
          stepped[4*i +: 4] = dig - 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrapped = carry;
  end

  // Non-decimal load digits are replaced by zero
  always_comb begin
    loaded = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      loaded[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      bcd  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        bcd  <= loaded;
        pcnt <= '0;
      end else if (en) begin
        if (step_int) begin
          pcnt <= '0;
          bcd  <= stepped;
          tick <= 1'b1;
          wrap <= wrapped;
        end else begin
          pcnt <= pcnt + PW'(1);
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = SEG_OFF;
    endcase
  endfunction

  // Walk from the most significant digit; a digit is leading while it and all above are zero
  always_comb begin
    logic lead;
    seg  = '1;
    lead = 1'b1;
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      lead = lead && (bcd[4*i +: 4] == 4'd0);
      if (blank_lz && lead && (i != 0)) begin
        seg[7*i +: 7] = SEG_OFF;
      end else begin
        seg[7*i +: 7] = seg7(bcd[4*i +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: a 2-digit DIV=4 instance and a 4-digit DIV=1 instance,
// both compared every cycle against an integer-valued model of the counter.
module tb_bcd_counter_display;

  typedef struct {
    int val;
    int pcnt;
    bit tick;
    bit wrap;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_en, a_up, a_load, a_blank_lz;
  logic [7:0]  a_load_val, a_bcd;
  logic [13:0] a_seg;
  logic        a_tick, a_wrap;

  logic        b_rst, b_en, b_up, b_load, b_blank_lz;
  logic [15:0] b_load_val, b_bcd;
  logic [27:0] b_seg;
  logic        b_tick, b_wrap;

  int ncmp = 0;
  int nfail = 0;
  model_t ma, mb;

  bcd_counter_display #(.NDIG(2), .DIV(4)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_load_val), .blank_lz(a_blank_lz),
    .bcd(a_bcd), .seg(a_seg), .tick(a_tick), .wrap(a_wrap)
  );

  bcd_counter_display #(.NDIG(4), .DIV(1)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load),
    .load_val(b_load_val), .blank_lz(b_blank_lz),
    .bcd(b_bcd), .seg(b_seg), .tick(b_tick), .wrap(b_wrap)
  );

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic model_t mnext(input model_t m, input int ndig, input int div,
                                   input bit r, input bit ld, input bit e, input bit u,
                                   input logic [31:0] lv);
    model_t n = m;
    int modv = pow10(ndig);
    int d;
    n.tick = 1'b0;
    n.wrap = 1'b0;
    if (r) begin
      n.val = 0;
      n.pcnt = 0;
    end else if (ld) begin
      n.val = 0;
      for (int i = ndig - 1; i >= 0; i--) begin
        d = int'(lv[4*i +: 4]);
        if (d > 9) d = 0;
        n.val = n.val * 10 + d;
      end
      n.pcnt = 0;
    end else if (e) begin
      if (m.pcnt == div - 1) begin
        n.pcnt = 0;
        n.tick = 1'b1;
        if (u) begin
          n.wrap = (m.val == modv - 1);
          n.val = (m.val + 1) % modv;
        end else begin
          n.wrap = (m.val == 0);
          n.val = (m.val + modv - 1) % modv;
        end
      end else begin
        n.pcnt = m.pcnt + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int ndig);
    logic [31:0] r = '0;
    for (int i = 0; i < ndig; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [55:0] exp_seg(input int v, input int ndig, input bit blz);
    logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [55:0] r = '0;
    int p;
    for (int i = 0; i < ndig; i++) begin
      p = pow10(i);
      if (blz && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
      else r[7*i +: 7] = codes[(v / p) % 10];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance both models with the inputs the DUTs saw, then compare all outputs
  task automatic cycle();
    @(posedge clk);
    ma = mnext(ma, 2, 4, a_rst, a_load, a_en, a_up, 32'(a_load_val));
    mb = mnext(mb, 4, 1, b_rst, b_load, b_en, b_up, 32'(b_load_val));
    #1;
    chk("a_bcd",  64'(a_bcd),  64'(to_bcd(ma.val, 2)));
    chk("a_seg",  64'(a_seg),  64'(exp_seg(ma.val, 2, a_blank_lz)));
    chk("a_tick", 64'(a_tick), 64'(ma.tick));
    chk("a_wrap", 64'(a_wrap), 64'(ma.wrap));
    chk("b_bcd",  64'(b_bcd),  64'(to_bcd(mb.val, 4)));
    chk("b_seg",  64'(b_seg),  64'(exp_seg(mb.val, 4, b_blank_lz)));
    chk("b_tick", 64'(b_tick), 64'(mb.tick));
    chk("b_wrap", 64'(b_wrap), 64'(mb.wrap));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    ma = '{0, 0, 1'b0, 1'b0};
    mb = '{0, 0, 1'b0, 1'b0};
    a_rst = 1'b1; a_en = 1'b1; a_up = 1'b1; a_load = 1'b1; a_load_val = 8'h55; a_blank_lz = 1'b0;
    b_rst = 1'b1; b_en = 1'b1; b_up = 1'b1; b_load = 1'b1; b_load_val = 16'h1234; b_blank_lz = 1'b0;

    // Reset overrides load and en
    run(2);
    chk("rst_bcd",  64'(a_bcd),  64'(8'h00));
    chk("rst_seg",  64'(a_seg),  64'(14'b0000001_0000001));
    chk("rst_tick", 64'(a_tick), 64'(1'b0));
    chk("rst_wrap", 64'(a_wrap), 64'(1'b0));

    // 4-digit DIV=1: 9999 -> 0000 with wrap, then reset mid-run
    b_rst = 1'b0; b_load = 1'b1; b_load_val = 16'h9999; b_en = 1'b0;
    cycle();
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    cycle();
    chk("div1_bcd",  64'(b_bcd),  64'(16'h0000));
    chk("div1_tick", 64'(b_tick), 64'(1'b1));
    chk("div1_wrap", 64'(b_wrap), 64'(1'b1));
    run(3);
    chk("div1_run", 64'(b_bcd), 64'(16'h0003));
    b_rst = 1'b1;
    cycle();
    chk("div1_rst", 64'(b_bcd), 64'(16'h0000));
    b_rst = 1'b0;

    // Up count: one step per 4 enabled cycles
    a_rst = 1'b0; a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    run(40);
    chk("up_10steps", 64'(a_bcd), 64'(8'h10));
    a_load = 1'b1; a_load_val = 8'h98;
    cycle();
    a_load = 1'b0;
    run(4);
    chk("up_99", 64'(a_bcd), 64'(8'h99));
    chk("up_99_wrap", 64'(a_wrap), 64'(1'b0));
    run(4);
    chk("up_00", 64'(a_bcd), 64'(8'h00));
    chk("up_00_wrap", 64'(a_wrap), 64'(1'b1));

    // Down count with borrow
    a_load = 1'b1; a_load_val = 8'h10;
    cycle();
    a_load = 1'b0; a_up = 1'b0;
    run(4);
    chk("dn_09", 64'(a_bcd), 64'(8'h09));
    chk("dn_09_wrap", 64'(a_wrap), 64'(1'b0));
    a_load = 1'b1; a_load_val = 8'h00;
    cycle();
    a_load = 1'b0;
    run(4);
    chk("dn_99", 64'(a_bcd), 64'(8'h99));
    chk("dn_99_wrap", 64'(a_wrap), 64'(1'b1));

    // Hold: partial prescale survives en=0
    run(2);
    a_en = 1'b0;
    run(20);
    chk("hold_bcd", 64'(a_bcd), 64'(8'h99));
    a_en = 1'b1;
    cycle();
    chk("hold_notick", 64'(a_tick), 64'(1'b0));
    cycle();
    chk("hold_step", 64'(a_bcd), 64'(8'h98));
    chk("hold_tick", 64'(a_tick), 64'(1'b1));

    // Load coinciding with a step wins; invalid low digit loads as 0
    a_up = 1'b1;
    run(3);
    a_load = 1'b1; a_load_val = 8'h3C;
    cycle();
    chk("ldpri_bcd",  64'(a_bcd),  64'(8'h30));
    chk("ldpri_tick", 64'(a_tick), 64'(1'b0));

    // Leading-zero blanking
    a_en = 1'b0; a_load_val = 8'h07; a_blank_lz = 1'b1;
    cycle();
    chk("blank_07", 64'(a_seg), 64'(14'b1111111_0001111));
    a_load_val = 8'h00;
    cycle();
    chk("blank_00", 64'(a_seg), 64'(14'b1111111_0000001));
    a_load = 1'b0; a_blank_lz = 1'b0;
    cycle();
    chk("noblank_00", 64'(a_seg), 64'(14'b0000001_0000001));

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      a_rst = ($urandom_range(0, 63) == 0);
      a_load = ($urandom_range(0, 15) == 0);
      a_en = ($urandom_range(0, 3) != 0);
      a_up = 1'($urandom);
      a_blank_lz = 1'($urandom);
      a_load_val = 8'($urandom);
      b_rst = ($urandom_range(0, 63) == 0);
      b_load = ($urandom_range(0, 15) == 0);
      b_en = ($urandom_range(0, 3) != 0);
      b_up = 1'($urandom);
      b_blank_lz = 1'($urandom);
      b_load_val = 16'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
